// File: rtl/utf8_char_assembler.sv
// -----------------------------------------------------------------------------
// utf8_char_assembler
//
// Purpose:
//   Sits between the UART byte receiver and the text-buffer memory array.
//   Raw bytes are assembled into right-aligned UTF-8 character codes of 1 to 3
//   bytes, with the first byte most significant. Single-byte control keys are
//   normalised: BS becomes DEL, LF becomes CR, and CRLF collapses to one CR.
//   Completed characters are queued in a small FIFO.
//
//   Each character is presented on o_char_code with a level strobe
//   o_char_ready. The strobe is held high for HOLD_CYCLES cycles and then held
//   low for at least GAP_CYCLES cycles. The array's edge-style latch therefore
//   sees exactly one write per character.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   i_rx_byte      received byte, qualified by i_rx_valid
//   i_rx_valid     single-cycle byte strobe from the UART receiver
//   i_clear_flags  synchronous clear of o_overflow
//   o_char_code    packed character code (to array data_in)
//   o_char_ready   data-ready level strobe (to array data_ready)
//   o_fifo_count   number of queued characters
//   o_overflow     sticky; a completed character was dropped on a full FIFO
//   o_seq_error    one-cycle pulse on a malformed or timed-out sequence
// -----------------------------------------------------------------------------
module utf8_char_assembler #(
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  i_rx_byte,
    input  logic                        i_rx_valid,
    input  logic                        i_clear_flags,
    output logic [23:0]                 o_char_code,
    output logic                        o_char_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_overflow,
    output logic                        o_seq_error
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int OC_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int OC_W   = $clog2(OC_MAX + 1);

    typedef enum logic [1:0] {
        ASM_IDLE  = 2'd0,
        ASM_NEED2 = 2'd1,
        ASM_NEED1 = 2'd2
    } asm_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_HOLD = 2'd1,
        OUT_GAP  = 2'd2
    } out_state_t;

    // Single-byte control-key mapping: BS -> DEL, LF -> CR.
    function automatic logic [7:0] norm_ctrl(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b == 8'h08)
            r = 8'h7F;
        else if (b == 8'h0A)
            r = 8'h0D;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    asm_state_t         r_asm_state;
    logic [15:0]        r_acc;          // partial sequence, lead byte in low byte until shifted
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_last_was_cr;

    logic [23:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    out_state_t         r_out_state;
    logic [OC_W-1:0]    r_out_cnt;
    logic               r_load;         // popped entry waiting in r_pend
    logic [23:0]        r_pend;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic               w_is_cont;
    logic               w_is_ascii;
    logic               w_is_lead2;
    logic               w_is_lead3;

    asm_state_t         w_asm_nx;
    logic [15:0]        w_acc_nx;
    logic [TMO_W-1:0]   w_tmo_nx;
    logic               w_cr_nx;
    logic               w_push;
    logic [23:0]        w_push_code;
    logic               w_err;
    logic               w_reproc;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;

    always_comb begin
        w_is_cont  = (i_rx_byte[7:6] == 2'b10);
        w_is_ascii = ~i_rx_byte[7];
        w_is_lead2 = (i_rx_byte >= 8'hC2) && (i_rx_byte <= 8'hDF);
        w_is_lead3 = (i_rx_byte[7:4] == 4'hE);
    end

    // Assembler next-state. A non-continuation byte arriving mid-sequence
    // aborts the partial character and is then handled as if the assembler
    // were idle, so a fresh lead byte is never lost.
    always_comb begin
        w_asm_nx    = r_asm_state;
        w_acc_nx    = r_acc;
        w_tmo_nx    = r_tmo_cnt;
        w_cr_nx     = r_last_was_cr;
        w_push      = 1'b0;
        w_push_code = 24'h0;
        w_err       = 1'b0;
        w_reproc    = 1'b0;

        if (i_rx_valid) begin
            w_tmo_nx = '0;
            if (r_asm_state == ASM_IDLE) begin
                w_reproc = 1'b1;
            end else if (w_is_cont) begin
                if (r_asm_state == ASM_NEED2) begin
                    w_acc_nx = {r_acc[7:0], i_rx_byte};
                    w_asm_nx = ASM_NEED1;
                end else begin
                    w_push      = 1'b1;
                    w_push_code = {r_acc, i_rx_byte};
                    w_cr_nx     = 1'b0;
                    w_asm_nx    = ASM_IDLE;
                end
            end else begin
                w_err    = 1'b1;
                w_reproc = 1'b1;
            end

            if (w_reproc) begin
                w_asm_nx = ASM_IDLE;
                if (w_is_ascii) begin
                    if ((i_rx_byte == 8'h0A) && r_last_was_cr) begin
                        // LF of a CRLF pair: swallowed, and it ends the pair.
                        w_cr_nx = 1'b0;
                    end else begin
                        w_push      = 1'b1;
                        w_push_code = {16'h0, norm_ctrl(i_rx_byte)};
                        w_cr_nx     = (i_rx_byte == 8'h0D);
                    end
                end else if (w_is_lead2) begin
                    w_acc_nx = {8'h00, i_rx_byte};
                    w_asm_nx = ASM_NEED1;
                end else if (w_is_lead3) begin
                    w_acc_nx = {8'h00, i_rx_byte};
                    w_asm_nx = ASM_NEED2;
                end else begin
                    // Stray continuation, C0/C1 overlong leads, or F0-FF.
                    w_err = 1'b1;
                end
            end
        end else if (r_asm_state != ASM_IDLE) begin
            if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                w_err    = 1'b1;
                w_asm_nx = ASM_IDLE;
                w_tmo_nx = '0;
            end else begin
                w_tmo_nx = r_tmo_cnt + TMO_W'(1);
            end
        end
    end

    // The queue is also drained on the last gap cycle. The next character
    // then rises exactly GAP_CYCLES+1 cycles after the previous one fell.
    always_comb begin
        w_full    = (r_count == CNT_W'(FIFO_DEPTH));
        w_empty   = (r_count == '0);
        w_pop     = !w_empty &&
                    (((r_out_state == OUT_IDLE) && !r_load) ||
                     ((r_out_state == OUT_GAP) && (r_out_cnt == OC_W'(GAP_CYCLES - 1))));
        w_push_ok = w_push && (!w_full || w_pop);
    end

    // ------------------------------------------------------------------
    // Assembler state and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm_state   <= ASM_IDLE;
            r_tmo_cnt     <= '0;
            r_last_was_cr <= 1'b0;
            o_seq_error   <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            r_asm_state   <= w_asm_nx;
            r_tmo_cnt     <= w_tmo_nx;
            r_last_was_cr <= w_cr_nx;
            o_seq_error   <= w_err;
            if (w_push && w_full && !w_pop)
                o_overflow <= 1'b1;
            else if (i_clear_flags)
                o_overflow <= 1'b0;
        end
    end

    // Datapath storage that needs no reset: never read before being written.
    always_ff @(posedge clk) begin
        r_acc <= w_acc_nx;
        if (w_push_ok)
            r_mem[r_wr_ptr] <= w_push_code;
        if (w_pop)
            r_pend <= r_mem[r_rd_ptr];
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_fifo_count = r_count;

    // ------------------------------------------------------------------
    // Output strobe FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_state  <= OUT_IDLE;
            r_out_cnt    <= '0;
            r_load       <= 1'b0;
            o_char_code  <= 24'h0;
            o_char_ready <= 1'b0;
        end else begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (r_load) begin
                        o_char_code  <= r_pend;
                        o_char_ready <= 1'b1;
                        r_load       <= 1'b0;
                        r_out_cnt    <= '0;
                        r_out_state  <= OUT_HOLD;
                    end else if (w_pop) begin
                        r_load <= 1'b1;
                    end
                end
                OUT_HOLD: begin
                    if (r_out_cnt == OC_W'(HOLD_CYCLES - 1)) begin
                        o_char_ready <= 1'b0;
                        r_out_cnt    <= '0;
                        r_out_state  <= OUT_GAP;
                    end else begin
                        r_out_cnt <= r_out_cnt + OC_W'(1);
                    end
                end
                OUT_GAP: begin
                    if (r_out_cnt == OC_W'(GAP_CYCLES - 1)) begin
                        r_out_cnt   <= '0;
                        r_out_state <= OUT_IDLE;
                        if (w_pop)
                            r_load <= 1'b1;
                    end else begin
                        r_out_cnt <= r_out_cnt + OC_W'(1);
                    end
                end
                default: begin
                    r_out_state  <= OUT_IDLE;
                    r_out_cnt    <= '0;
                    r_load       <= 1'b0;
                    o_char_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_utf8_char_assembler.sv
// -----------------------------------------------------------------------------
// tb_utf8_char_assembler
//
// Purpose:
//   Directed self-checking bench for utf8_char_assembler.
//   Bytes are driven on the falling edge of clk.
//   A falling-edge monitor records each presented character, how long the
//   strobe was high, how long it was low before the character, and the number
//   of seq_error pulses.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_utf8_char_assembler;

    localparam int HOLD  = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 20;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [7:0]             rx_byte = 8'h00;
    logic                   rx_valid = 1'b0;
    logic                   clear_flags = 1'b0;
    logic [23:0]            char_code;
    logic                   char_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   seq_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    utf8_char_assembler #(
        .HOLD_CYCLES    (HOLD),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (DEPTH)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_rx_byte     (rx_byte),
        .i_rx_valid    (rx_valid),
        .i_clear_flags (clear_flags),
        .o_char_code   (char_code),
        .o_char_ready  (char_ready),
        .o_fifo_count  (fifo_count),
        .o_overflow    (overflow),
        .o_seq_error   (seq_error)
    );

    // Falling-edge monitor: records presented characters and strobe timing.
    logic [23:0] q_code[$];
    int          q_hi[$];
    int          q_lo[$];
    int          n_seqerr = 0;
    logic        prev_rdy = 1'b0;
    int          hi_len = 0;
    int          lo_len = 1000;

    always @(negedge clk) begin
        if (reset) begin
            prev_rdy = 1'b0;
            hi_len   = 0;
            lo_len   = 1000;
        end else begin
            if (char_ready && !prev_rdy) begin
                q_code.push_back(char_code);
                q_lo.push_back(lo_len);
                hi_len = 1;
            end else if (char_ready) begin
                hi_len++;
            end
            if (!char_ready && prev_rdy) begin
                q_hi.push_back(hi_len);
                lo_len = 1;
            end else if (!char_ready) begin
                lo_len++;
            end
            if (seq_error)
                n_seqerr++;
            prev_rdy = char_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
    endtask

    task automatic release_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        q_code.delete();
        q_hi.delete();
        q_lo.delete();
        n_seqerr = 0;
    endtask

    function automatic logic [31:0] code_at(input int i);
        return (q_code.size() > i) ? {8'h00, q_code[i]} : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] hi_at(input int i);
        return (q_hi.size() > i) ? q_hi[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] lo_ok(input int i);
        return (q_lo.size() > i) ? {31'h0, (q_lo[i] >= GAP)} : 32'hDEADBEEF;
    endfunction

    initial begin
        // Reset state
        wait_cyc(3);
        chk("rst_code",   char_code,  0);
        chk("rst_ready",  char_ready, 0);
        chk("rst_count",  fifo_count, 0);
        chk("rst_ovf",    overflow,   0);
        chk("rst_seqerr", seq_error,  0);
        reset = 1'b0;
        wait_cyc(2);

        // Single ASCII byte: latency, hold length, drain
        clear_mon();
        send(8'h41);
        release_rx();
        chk("s1_ready_e0", char_ready, 0);
        chk("s1_count_e0", fifo_count, 1);
        wait_cyc(1);
        chk("s1_ready_e1", char_ready, 0);
        chk("s1_count_e1", fifo_count, 0);
        wait_cyc(1);
        chk("s1_ready_e2", char_ready, 1);
        chk("s1_code_e2",  char_code,  24'h000041);
        wait_cyc(20);
        chk("s1_nchars", q_code.size(), 1);
        chk("s1_hold",   hi_at(0), HOLD);
        chk("s1_count",  fifo_count, 0);
        chk("s1_ready",  char_ready, 0);
        chk("s1_code_held", char_code, 24'h000041);

        // 3-byte then 2-byte sequence back-to-back
        clear_mon();
        send(8'hE0); send(8'hB8); send(8'h81); send(8'hC3); send(8'hA9);
        release_rx();
        wait_cyc(40);
        chk("s2_nchars", q_code.size(), 2);
        chk("s2_code0",  code_at(0), 32'h00E0B881);
        chk("s2_code1",  code_at(1), 32'h0000C3A9);
        chk("s2_hold0",  hi_at(0), HOLD);
        chk("s2_hold1",  hi_at(1), HOLD);
        chk("s2_gap1",   lo_ok(1), 1);
        chk("s2_seqerr", n_seqerr, 0);

        // Control-key normalisation: CR LF LF BS
        clear_mon();
        send(8'h0D); send(8'h0A); send(8'h0A); send(8'h08);
        release_rx();
        wait_cyc(50);
        chk("s3_nchars", q_code.size(), 3);
        chk("s3_code0",  code_at(0), 32'h0000000D);
        chk("s3_code1",  code_at(1), 32'h0000000D);
        chk("s3_code2",  code_at(2), 32'h0000007F);
        chk("s3_gap1",   lo_ok(1), 1);
        chk("s3_gap2",   lo_ok(2), 1);
        chk("s3_seqerr", n_seqerr, 0);

        // Interrupted sequence, stray continuation, invalid bytes
        clear_mon();
        send(8'hE0); send(8'h41);
        release_rx();
        wait_cyc(20);
        chk("s4_abort_err",  n_seqerr, 1);
        chk("s4_abort_n",    q_code.size(), 1);
        chk("s4_abort_code", code_at(0), 32'h00000041);
        clear_mon();
        send(8'h85);
        release_rx();
        wait_cyc(10);
        chk("s4_cont_err", n_seqerr, 1);
        chk("s4_cont_n",   q_code.size(), 0);
        clear_mon();
        send(8'hFF); send(8'hC0);
        release_rx();
        wait_cyc(10);
        chk("s4_inv_err", n_seqerr, 2);
        chk("s4_inv_n",   q_code.size(), 0);

        // Timeout of an incomplete sequence
        clear_mon();
        send(8'hE0);
        release_rx();
        wait_cyc(15);
        chk("s5_no_early_tmo", n_seqerr, 0);
        wait_cyc(10);
        chk("s5_tmo_err", n_seqerr, 1);
        send(8'h42);
        release_rx();
        wait_cyc(20);
        chk("s5_n",      q_code.size(), 1);
        chk("s5_code",   code_at(0), 32'h00000042);
        chk("s5_err_after", n_seqerr, 1);

        // FIFO overflow with six consecutive bytes
        clear_mon();
        for (int i = 0; i < 6; i++)
            send(8'h41 + 8'(i));
        release_rx();
        chk("s6_count_full", fifo_count, DEPTH);
        chk("s6_ovf_set",    overflow,   1);
        wait_cyc(5);
        chk("s6_ovf_sticky", overflow, 1);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("s6_ovf_clear", overflow, 0);
        wait_cyc(60);
        chk("s6_n", q_code.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("s6_code%0d", i), code_at(i), 32'h41 + i);
        chk("s6_count_end", fifo_count, 0);
        chk("s6_seqerr",    n_seqerr, 0);

        // Reset asserted mid-hold with characters still queued
        clear_mon();
        send(8'h51); send(8'h52); send(8'h53);
        release_rx();
        chk("s7_ready_pre", char_ready, 1);
        chk("s7_code_pre",  char_code,  24'h000051);
        chk("s7_count_pre", fifo_count, 2);
        wait_cyc(1);
        #2;
        reset = 1'b1;
        #1;
        chk("s7_ready_async", char_ready, 0);
        chk("s7_count_async", fifo_count, 0);
        chk("s7_code_async",  char_code,  0);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(30);
        chk("s7_n_after",     q_code.size(), 1);
        chk("s7_ready_after", char_ready, 0);
        chk("s7_count_after", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
